frogger_game_ctrl: RTL
======================

// Module: frogger_game_ctrl
// PURPOSE
//   Game-state sequencer between the collision/win detection in the Frogger top level and the
//   display, LED and car-timing logic. Consumes collision and win pulses; owns lives, 2-digit BCD
//   score and car-step period. Issues one-cycle frog respawn pulses and a freeze flag that stalls
//   car motion and input during death pause, attract and game-over.
// PARAMETERS
//   LIVES_INIT     3           lives at game start (1..4)
//   SPEED_INIT     166667      initial car-step period, i_CLK cycles
//   SPEED_STEP     8333        period decrement per level-up
//   SPEED_MIN      83333       period floor; never go below
//   LEVEL_EVERY    3           wins per level-up (>=1)
//   DEATH_HOLD     25000000    freeze cycles after losing a life (1 s at 25 MHz)
// PORTS
//   i_CLK          in   1   system clock (25 MHz pixel clock)
//   i_RST          in   1   synchronous reset, active-high
//   i_Collision    in   1   frog/car overlap, level; sampled each cycle
//   i_Win          in   1   frog reached row 0, one-cycle pulse
//   i_Start        in   1   debounced button press, one-cycle pulse
//   o_State        out  2   0=IDLE 1=PLAY 2=DEATH 3=OVER
//   o_Freeze       out  1   1 = cars and frog input stalled
//   o_Respawn      out  1   one-cycle pulse: frog to (10,14), facing up
//   o_Lives        out  3   remaining lives
//   o_LED          out  4   thermometer, o_LED[k] = (o_Lives > k)
//   o_Score_Tens   out  4   BCD tens digit, 0..9
//   o_Score_Ones   out  4   BCD ones digit, 0..9
//   o_Car_Period   out  32  car-step period to the car mover
// BEHAVIOUR
//   - One clock, i_RST synchronous active-high. All outputs registered.
//   - Reset values: State=IDLE, Freeze=1, Respawn=0, Lives=LIVES_INIT, LED per Lives,
//     Score=00, Car_Period=SPEED_INIT, level counter=0, hold counter=0.
//   - Reset mid-operation: same values on the next edge; abandons any pending hold.
//   - IDLE: Freeze=1. i_Start -> PLAY, Freeze=0, Respawn=1 on the next cycle.
//   - PLAY, Freeze=0:
//     i_Collision=1 -> Lives-1.
//       Result 0 -> OVER.
//       Else -> DEATH, hold counter=0.
//       Freeze=1 either way.
//     i_Win=1 with i_Collision=0 -> Score+1 BCD, saturating at 99.
//       Ones 9 -> 0 carries into tens. At 99 the score holds; level logic still runs.
//       Level counter +1. On reaching LEVEL_EVERY it clears to 0 and
//       Car_Period = max(Car_Period-SPEED_STEP, SPEED_MIN); no underflow.
//       Respawn=1 next cycle; stay PLAY.
//     Same cycle collision and win: the collision wins and the win is dropped.
//   - DEATH: Freeze=1; i_Collision, i_Win, i_Start ignored.
//     Hold counter counts DEATH_HOLD cycles. On the last count -> PLAY, Freeze=0, Respawn=1.
//   - OVER: Freeze=1; Lives=0, LED=0000; score frozen for display.
//     i_Start reloads Lives, Score=00, Car_Period=SPEED_INIT, level counter=0
//     -> PLAY, Respawn=1.
//   - o_Respawn is high exactly one cycle per event and never in IDLE, DEATH or OVER holds.
//   - i_Collision still high after respawn, frog spawned in a lane:
//     counts again on the first PLAY cycle. No masking.
//   - Latency: every output updates one edge after the triggering input.
// TESTING  (bench: DEATH_HOLD=4, SPEED_INIT=100, SPEED_STEP=10, SPEED_MIN=75)
//   1 Reset, i_Start pulse
//     -> State 0->1, Respawn high 1 cycle, Lives=3, LED=0111, Score=00, Period=100.
//   2 Three i_Win pulses
//     -> Score 01,02,03; Period 100,100,90; Respawn high 3 times.
//     Nine further wins -> Period 80, then 75 (floor held), then 75.
//   3 i_Collision high 1 cycle in PLAY
//     -> Lives=2, LED=0011, State=DEATH, Freeze=1.
//     Freeze=1 for 4 cycles, then PLAY with Respawn pulse. Inputs during hold ignored.
//   4 i_Collision and i_Win together
//     -> Lives-1, score unchanged, State=DEATH.
//   5 Lose all 3 lives
//     -> State=OVER, LED=0000, score kept.
//     i_Start -> Lives=3, Score=00, Period=100, PLAY, Respawn pulse.
//   6 Drive score to 99, then i_Win -> stays 99.
//     Assert i_RST in DEATH mid-hold -> all reset values next edge, State=IDLE.

Source files
------------

// File: rtl/frogger_game_ctrl.sv
// Frogger game-state sequencer: owns lives, BCD score, car-step period and the
// death-pause timer; issues one-cycle respawn pulses and the freeze flag that
// stalls cars and frog input outside active play.
module frogger_game_ctrl #(
   parameter int LIVES_INIT  = 3,
   parameter int SPEED_INIT  = 166667,
   parameter int SPEED_STEP  = 8333,
   parameter int SPEED_MIN   = 83333,
   parameter int LEVEL_EVERY = 3,
   parameter int DEATH_HOLD  = 25000000
) (
   input  logic        i_CLK,
   input  logic        i_RST,
   input  logic        i_Collision,
   input  logic        i_Win,
   input  logic        i_Start,
   output logic [1:0]  o_State,
   output logic        o_Freeze,
   output logic        o_Respawn,
   output logic [2:0]  o_Lives,
   output logic [3:0]  o_LED,
   output logic [3:0]  o_Score_Tens,
   output logic [3:0]  o_Score_Ones,
   output logic [31:0] o_Car_Period
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_DEATH = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   // Thermometer code for the lives LEDs: bit k lit while more than k lives remain.
   function automatic logic [3:0] lives_to_led(input logic [2:0] lives);
      logic [3:0] led;
      for (int k = 0; k < 4; k++) begin
         led[k] = (lives > 3'(k));
      end
      return led;
   endfunction

   state_t      r_state, w_state;
   logic        r_freeze, w_freeze;
   logic        r_respawn, w_respawn;
   logic [2:0]  r_lives, w_lives;
   logic [3:0]  r_led, w_led;
   logic [3:0]  r_tens, w_tens;
   logic [3:0]  r_ones, w_ones;
   logic [31:0] r_period, w_period;
   logic [31:0] r_level, w_level;
   logic [31:0] r_hold, w_hold;

   // Next-state and next-output logic for the game sequencer.
   always_comb begin
      w_state   = r_state;
      w_respawn = 1'b0;
      w_lives   = r_lives;
      w_tens    = r_tens;
      w_ones    = r_ones;
      w_period  = r_period;
      w_level   = r_level;
      w_hold    = r_hold;
      case (r_state)
         S_IDLE: begin
            if (i_Start) begin
               w_state   = S_PLAY;
               w_respawn = 1'b1;
            end else begin
               w_state = S_IDLE;
            end
         end
         S_PLAY: begin
            // A collision always beats a simultaneous win.
            if (i_Collision) begin
               if (r_lives <= 3'd1) begin
                  w_lives = 3'd0;
                  w_state = S_OVER;
               end else begin
                  w_lives = r_lives - 3'd1;
                  w_state = S_DEATH;
                  w_hold  = 32'd0;
               end
            end else if (i_Win) begin
               w_respawn = 1'b1;
               // Score saturates at 99; level progression keeps running.
               if ((r_tens == 4'd9) && (r_ones == 4'd9)) begin
                  w_tens = r_tens;
                  w_ones = r_ones;
               end else if (r_ones == 4'd9) begin
                  w_ones = 4'd0;
                  w_tens = r_tens + 4'd1;
               end else begin
                  w_ones = r_ones + 4'd1;
               end
               if (r_level >= 32'(LEVEL_EVERY - 1)) begin
                  w_level = 32'd0;
                  // Compare before subtracting so the period never wraps.
                  if (r_period >= 32'(SPEED_MIN + SPEED_STEP)) begin
                     w_period = r_period - 32'(SPEED_STEP);
                  end else begin
                     w_period = 32'(SPEED_MIN);
                  end
               end else begin
                  w_level = r_level + 32'd1;
               end
            end else begin
               w_state = S_PLAY;
            end
         end
         S_DEATH: begin
            // Inputs are ignored until the pause has run its full length.
            if (r_hold >= 32'(DEATH_HOLD - 1)) begin
               w_hold    = 32'd0;
               w_state   = S_PLAY;
               w_respawn = 1'b1;
            end else begin
               w_hold = r_hold + 32'd1;
            end
         end
         S_OVER: begin
            if (i_Start) begin
               w_lives   = 3'(LIVES_INIT);
               w_tens    = 4'd0;
               w_ones    = 4'd0;
               w_period  = 32'(SPEED_INIT);
               w_level   = 32'd0;
               w_state   = S_PLAY;
               w_respawn = 1'b1;
            end else begin
               w_lives = 3'd0;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
      w_freeze = (w_state != S_PLAY);
      w_led    = lives_to_led(w_lives);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         r_state   <= S_IDLE;
         r_freeze  <= 1'b1;
         r_respawn <= 1'b0;
         r_lives   <= 3'(LIVES_INIT);
         r_led     <= lives_to_led(3'(LIVES_INIT));
         r_tens    <= 4'd0;
         r_ones    <= 4'd0;
         r_period  <= 32'(SPEED_INIT);
         r_level   <= 32'd0;
         r_hold    <= 32'd0;
      end else begin
         r_state   <= w_state;
         r_freeze  <= w_freeze;
         r_respawn <= w_respawn;
         r_lives   <= w_lives;
         r_led     <= w_led;
         r_tens    <= w_tens;
         r_ones    <= w_ones;
         r_period  <= w_period;
         r_level   <= w_level;
         r_hold    <= w_hold;
      end
   end

   assign o_State      = r_state;
   assign o_Freeze     = r_freeze;
   assign o_Respawn    = r_respawn;
   assign o_Lives      = r_lives;
   assign o_LED        = r_led;
   assign o_Score_Tens = r_tens;
   assign o_Score_Ones = r_ones;
   assign o_Car_Period = r_period;

endmodule
